// File: rtl/colcmp_pkg.sv
// rtl/colcmp_pkg.sv - shared sizes and state encoding for the column comparator
//   NCOLS    columns per bitmap / template depth
//   COLW     column slice width
//   SCORE_W  score width (covers NCOLS*COLW = 1536)
//   IDX_W    column index width
//   TMO_W    wait-for-colready counter width
//   state_t  IDLE, REQ, WAIT, ACC, FIN
package colcmp_pkg;

  localparam int NCOLS   = 24;
  localparam int COLW    = 64;
  localparam int SCORE_W = 11;
  localparam int IDX_W   = 5;
  localparam int TMO_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    ACC,
    FIN
  } state_t;

endpackage

// File: rtl/colcmp_acc_popcount64.sv
// rtl/colcmp_acc_popcount64.sv - combinational 64-bit population count
//   data   in   64  bits to count
//   count  out  7   number of set bits, 0..64
module popcount64 (
  input  logic [63:0] data,
  output logic [6:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 64; i++) begin
      count = count + {6'b0, data[i]};
    end
  end

endmodule

// File: rtl/colcmp_acc.sv
// rtl/colcmp_acc.sv - bitmap column comparator with template RAM and similarity score
//   clk, rst              clock, synchronous active-high reset
//   start                 begins a comparison (ignored while busy)
//   colin, colready       column slice and its one-cycle valid strobe
//   lastcolumn            source is at its final column
//   nextcol               one-cycle request for the next column
//   tmpl_wren/addr/data   template column write port (ignored while busy)
//   mask_wren, mask_data  care-mask write port at tmpl_addr (CMP_MASK_EN only)
//   busy, done            run in progress, one-cycle completion pulse
//   score, match, err     matching-bit total, score >= THRESH, timeout abort
// Optional feature macro: CMP_MASK_EN adds a per-bit care mask (reset to all ones).
module colcmp_acc
  import colcmp_pkg::*;
#(
  parameter int THRESH  = 1400,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COLW-1:0]    colin,
  input  logic               colready,
  input  logic               lastcolumn,
  output logic               nextcol,
  input  logic               tmpl_wren,
  input  logic [IDX_W-1:0]   tmpl_addr,
  input  logic [COLW-1:0]    tmpl_data,
`ifdef CMP_MASK_EN
  input  logic               mask_wren,
  input  logic [COLW-1:0]    mask_data,
`endif
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic               match,
  output logic               err
);

  localparam logic [TMO_W-1:0]   TMO_LIM  = TMO_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NCOLS - 1);
  localparam logic [SCORE_W-1:0] THR      = SCORE_W'(THRESH);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [TMO_W-1:0]   wcnt;
  logic [COLW-1:0]    colin_q;
  logic               last_q;
  logic [COLW-1:0]    tmpl_mem [NCOLS];
  logic [COLW-1:0]    care;
  logic [6:0]         col_hits;
  logic               addr_ok;

  assign addr_ok = (tmpl_addr < IDX_W'(NCOLS));

  // Template contents survive reset; writes are locked out during a run.
  always_ff @(posedge clk) begin
    if (tmpl_wren && !busy && addr_ok) begin
      tmpl_mem[tmpl_addr] <= tmpl_data;
    end
  end

`ifdef CMP_MASK_EN
  logic [COLW-1:0] mask_mem [NCOLS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCOLS; i++) begin
        mask_mem[i] <= '1;
      end
    end else if (mask_wren && !busy && addr_ok) begin
      mask_mem[tmpl_addr] <= mask_data;
    end
  end

  assign care = mask_mem[idx] & ~(colin_q ^ tmpl_mem[idx]);
`else
  assign care = ~(colin_q ^ tmpl_mem[idx]);
`endif

  popcount64 u_popcount (
    .data  (care),
    .count (col_hits)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      wcnt    <= '0;
      colin_q <= '0;
      last_q  <= 1'b0;
      nextcol <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      score   <= '0;
      match   <= 1'b0;
      err     <= 1'b0;
    end else begin
      nextcol <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            score   <= '0;
            match   <= 1'b0;
            err     <= 1'b0;
            idx     <= '0;
            busy    <= 1'b1;
            nextcol <= 1'b1;
            state   <= REQ;
          end
        end
        // nextcol was raised on entry so it is high for exactly the REQ cycle.
        REQ: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (colready) begin
            colin_q <= colin;
            last_q  <= lastcolumn;
            state   <= ACC;
          end else if (wcnt == TMO_LIM) begin
            err   <= 1'b1;
            state <= FIN;
          end else begin
            wcnt <= wcnt + TMO_W'(1);
          end
        end
        ACC: begin
          score <= score + SCORE_W'(col_hits);
          if (idx == LAST_IDX || last_q) begin
            state <= FIN;
          end else begin
            idx     <= idx + IDX_W'(1);
            nextcol <= 1'b1;
            state   <= REQ;
          end
        end
        FIN: begin
          match <= (score >= THR) && !err;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_colcmp_acc.sv
// tb/tb_colcmp_acc.sv - randomized self-checking bench for colcmp_acc
module tb_colcmp_acc;

  localparam int NC = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] colin;
  logic        colready;
  logic        lastcolumn;
  logic        tmpl_wren;
  logic [4:0]  tmpl_addr;
  logic [63:0] tmpl_data;

  logic        nextcol, busy, done, match, err;
  logic [10:0] score;
  logic        nextcol_hi, busy_hi, done_hi, match_hi, err_hi;
  logic [10:0] score_hi;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] tm   [NC];
  logic [63:0] cols [NC];

  always #5 clk = ~clk;

  colcmp_acc dut (
    .clk(clk), .rst(rst), .start(start), .colin(colin), .colready(colready),
    .lastcolumn(lastcolumn), .nextcol(nextcol), .tmpl_wren(tmpl_wren),
    .tmpl_addr(tmpl_addr), .tmpl_data(tmpl_data), .busy(busy), .done(done),
    .score(score), .match(match), .err(err)
  );

  colcmp_acc #(.THRESH(1500)) dut_hi (
    .clk(clk), .rst(rst), .start(start), .colin(colin), .colready(colready),
    .lastcolumn(lastcolumn), .nextcol(nextcol_hi), .tmpl_wren(tmpl_wren),
    .tmpl_addr(tmpl_addr), .tmpl_data(tmpl_data), .busy(busy_hi), .done(done_hi),
    .score(score_hi), .match(match_hi), .err(err_hi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic load_tmpl();
    for (int i = 0; i < NC; i++) begin
      @(negedge clk);
      tmpl_wren = 1'b1; tmpl_addr = 5'(i); tmpl_data = tm[i];
    end
    // out-of-range addresses must not disturb anything
    for (int a = NC; a < 32; a++) begin
      @(negedge clk);
      tmpl_wren = 1'b1; tmpl_addr = 5'(a); tmpl_data = {$urandom, $urandom};
    end
    @(negedge clk);
    tmpl_wren = 1'b0;
  endtask

  // last_at: column carrying lastcolumn (-1 none); stall_col: column never answered (-1 none);
  // rst_col: column whose WAIT gets a reset (-1 none); noise: stray starts/colready/template writes
  task automatic run_cmp(input string name, input int last_at, input int stall_col,
                         input int rst_col, input int max_dly, input bit noise);
    int cyc, nreq, sent, dly, sumdly, ndone, done_cyc, abort_cyc, n, exp_edge;
    bit pend;
    logic [31:0] exp_score;
    logic [10:0] g_score, g_score_hi;
    logic g_match, g_match_hi, g_err, g_err_hi, g_busy, g_nc_hi;
    bit exp_err;
    nreq = 0; sent = 0; dly = 0; sumdly = 0; ndone = 0; done_cyc = 0; abort_cyc = -1; pend = 0;
    g_score = '0; g_score_hi = '0; g_match = 0; g_match_hi = 0; g_err = 0; g_err_hi = 0;
    g_busy = 0; g_nc_hi = 0;
    @(negedge clk);
    start = 1'b1;
    for (cyc = 1; cyc < 1200; cyc++) begin
      @(negedge clk);
      start = 1'b0; colready = 1'b0; lastcolumn = 1'b0; tmpl_wren = 1'b0; rst = 1'b0;
      colin = {$urandom, $urandom};
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        check({name, " rst busy"}, busy, 0);
        check({name, " rst nextcol"}, nextcol, 0);
        check({name, " rst score"}, score, 0);
        check({name, " rst err"}, err, 0);
      end
      if (done) begin
        ndone++; done_cyc = cyc;
        g_score = score; g_match = match; g_err = err; g_busy = busy;
        g_score_hi = score_hi; g_match_hi = match_hi; g_err_hi = err_hi; g_nc_hi = nextcol_hi;
      end
      if (nextcol) begin
        nreq++; pend = 1;
        if (nreq - 1 == stall_col) dly = 1000000;
        else begin dly = $urandom_range(0, max_dly); sumdly += dly; end
      end else if (pend) begin
        if (nreq - 1 == rst_col) begin
          rst = 1'b1; pend = 0; abort_cyc = cyc;
        end else if (dly == 0) begin
          colready = 1'b1; colin = cols[sent]; lastcolumn = (sent == last_at); sent++; pend = 0;
        end else dly--;
      end else if (noise && $urandom_range(0, 2) == 0) begin
        colready = 1'b1; lastcolumn = 1'($urandom);
      end
      if (noise && busy && $urandom_range(0, 3) == 0) start = 1'b1;
      if (noise && busy && $urandom_range(0, 3) == 0) begin
        tmpl_wren = 1'b1; tmpl_addr = 5'($urandom_range(0, 31)); tmpl_data = {$urandom, $urandom};
      end
      if (ndone > 0 && cyc >= done_cyc + 4) break;
      if (abort_cyc >= 0 && cyc >= abort_cyc + 30) break;
    end
    start = 1'b0; colready = 1'b0; lastcolumn = 1'b0; tmpl_wren = 1'b0; rst = 1'b0;

    if (rst_col >= 0) begin
      check({name, " no done after rst"}, ndone, 0);
      check({name, " nextcol count"}, nreq, rst_col + 1);
    end else begin
      if (stall_col >= 0) begin
        n = stall_col; exp_err = 1;
        exp_edge = 3 * n + sumdly + 258;
        check({name, " nextcol count"}, nreq, n + 1);
      end else begin
        n = (last_at >= 0) ? last_at + 1 : NC; exp_err = 0;
        exp_edge = 3 * n + sumdly + 1;
        check({name, " nextcol count"}, nreq, n);
      end
      exp_score = 0;
      for (int i = 0; i < n; i++) exp_score += $countones(~(cols[i] ^ tm[i]));
      check({name, " done pulses"}, ndone, 1);
      check({name, " done edge"}, done_cyc - 1, exp_edge);
      check({name, " score"}, g_score, exp_score);
      check({name, " err"}, g_err, exp_err);
      check({name, " match"}, g_match, (exp_score >= 1400) && !exp_err);
      check({name, " match thr1500"}, g_match_hi, (exp_score >= 1500) && !exp_err);
      check({name, " score thr1500"}, g_score_hi, exp_score);
      check({name, " err thr1500"}, g_err_hi, exp_err);
      check({name, " busy at done"}, g_busy, 0);
      check({name, " nextcol thr1500 at done"}, g_nc_hi, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; colin = '0; colready = 1'b0; lastcolumn = 1'b0;
    tmpl_wren = 1'b0; tmpl_addr = '0; tmpl_data = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset nextcol", nextcol, 0);
    check("reset score", score, 0);
    check("reset match", match, 0);
    check("reset err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < NC; i++) tm[i] = '1;
    load_tmpl();

    for (int i = 0; i < NC; i++) cols[i] = '1;
    run_cmp("all ones", -1, -1, -1, 0, 0);
    for (int i = 0; i < NC; i++) cols[i] = '0;
    run_cmp("all zeros", -1, -1, -1, 0, 0);
    for (int i = 0; i < NC; i++) cols[i] = ~64'h7;
    run_cmp("three flips", -1, -1, -1, 0, 0);
    for (int i = 0; i < NC; i++) cols[i] = '1;
    run_cmp("timeout", -1, 5, -1, 0, 0);
    run_cmp("early last", 9, -1, -1, 0, 0);
    run_cmp("reset mid", -1, -1, 11, 0, 1);
    run_cmp("after reset", -1, -1, -1, 0, 1);

    for (int t = 0; t < 8; t++) begin
      int lst, stl;
      for (int i = 0; i < NC; i++) tm[i] = {$urandom, $urandom};
      load_tmpl();
      for (int i = 0; i < NC; i++) begin
        logic [63:0] f;
        f = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        if (t[0]) f = f & {$urandom, $urandom};
        cols[i] = tm[i] ^ f;
      end
      lst = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NC - 1) : -1;
      stl = (lst < 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, NC - 1) : -1;
      run_cmp($sformatf("random%0d", t), lst, stl, -1, 3, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
